// File: rtl/pkt_router_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spif_router_pkg
//  Purpose  : Shared constants and FSM state type for the multicast router.
//  Revision : 1.0 - initial release
// ============================================================================
package spif_router_pkg;

    localparam int KEY_BITS     = 32;
    localparam int PACKET_BITS  = 72;
    localparam int KEY_LSB      = 8;
    localparam int NUM_RREGS    = 16;
    localparam int NUM_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_router_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_router_mc_if
//  Purpose  : Packet ingress handshake plus per-channel egress handshakes.
//             slave = router side, master = assembler / FIFO side.
//  Revision : 1.0 - initial release
// ============================================================================
interface pkt_router_mc_if #(
    parameter int PACKET_BITS  = spif_router_pkg::PACKET_BITS,
    parameter int NUM_CHANNELS = spif_router_pkg::NUM_CHANNELS
);
    logic [PACKET_BITS-1:0]                   pkt_in_data_in;
    logic                                     pkt_in_vld_in;
    logic                                     pkt_in_rdy_out;
    logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] pkt_out_data_out;
    logic [NUM_CHANNELS-1:0]                  pkt_out_vld_out;
    logic [NUM_CHANNELS-1:0]                  pkt_out_rdy_in;

    modport slave (
        input  pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
        output pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out
    );

    modport master (
        output pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
        input  pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out
    );
endinterface
`default_nettype wire

// File: rtl/pkt_router_mc_match.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_router_mc_match
//  Purpose  : Combinational priority matcher; entry 0 has highest priority.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_router_mc_match
    import spif_router_pkg::*;
#(
    parameter int NUM_RREGS    = spif_router_pkg::NUM_RREGS,
    parameter int NUM_CHANNELS = spif_router_pkg::NUM_CHANNELS
) (
    input  logic [KEY_BITS-1:0]                  i_key,
    input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]   i_reg_key,
    input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]   i_reg_mask,
    input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0] i_reg_route,
    output logic                                 o_hit,
    output logic [NUM_CHANNELS-1:0]              o_route
);

    // Scan from the lowest-priority entry upward so the lowest index hit wins.
    always_comb begin
        o_hit   = 1'b0;
        o_route = '0;
        for (int i = NUM_RREGS - 1; i >= 0; i--) begin
            if ((i_key & i_reg_mask[i]) == i_reg_key[i]) begin
                o_hit   = 1'b1;
                o_route = i_reg_route[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_router_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_router_mc
//  Purpose  : Multicast packet router. Matches the packet key against a
//             priority routing table and offers one copy to every channel in
//             the winning route vector; stalled channels are dropped after
//             drop_wait_in SEND cycles (0 = wait forever).
//  Options  : PKT_ROUTER_MC_DROP_CNT_EN - enables the drop counter; when
//             undefined drp_cnt_out is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_router_mc
    import spif_router_pkg::*;
#(
    parameter int PACKET_BITS  = spif_router_pkg::PACKET_BITS,
    parameter int KEY_LSB      = spif_router_pkg::KEY_LSB,
    parameter int NUM_RREGS    = spif_router_pkg::NUM_RREGS,
    parameter int NUM_CHANNELS = spif_router_pkg::NUM_CHANNELS
) (
    input  logic                                   clk_tb,
    input  logic                                   reset_tb,
    input  logic [31:0]                            drop_wait_in,
    input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]     reg_key_in,
    input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]     reg_mask_in,
    input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0] reg_route_in,
    pkt_router_mc_if.slave                         bus,
    output logic [31:0]                            rt_cnt_out,
    output logic [31:0]                            drp_cnt_out
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PACKET_BITS-1:0]  r_pkt;
    logic [NUM_CHANNELS-1:0] r_pending;
    logic [31:0]             r_timer;
    logic [31:0]             r_rt_cnt;
    logic                    w_hit;
    logic [NUM_CHANNELS-1:0] w_route;
    logic [NUM_CHANNELS-1:0] w_pending_after;
    logic                    w_all_done;
    logic                    w_timeout;

    pkt_router_mc_match #(
        .NUM_RREGS    (NUM_RREGS),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_match (
        .i_key       (r_pkt[KEY_LSB +: KEY_BITS]),
        .i_reg_key   (reg_key_in),
        .i_reg_mask  (reg_mask_in),
        .i_reg_route (reg_route_in),
        .o_hit       (w_hit),
        .o_route     (w_route)
    );

    // Pending is only nonzero in SEND, so it doubles as the valid vector.
    assign bus.pkt_in_rdy_out  = (r_state == IDLE);
    assign bus.pkt_out_vld_out = r_pending;

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
            assign bus.pkt_out_data_out[c] = r_pkt;
        end
    endgenerate

    // Channels still owed a copy once this cycle's handshakes are applied.
    assign w_pending_after = r_pending & ~bus.pkt_out_rdy_in;
    assign w_all_done      = (w_pending_after == '0);
    assign w_timeout       = (drop_wait_in != 32'd0) &&
                             (r_timer == drop_wait_in - 32'd1) && !w_all_done;

    // State register.
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.pkt_in_vld_in) w_state_nxt = MATCH;
            MATCH:   w_state_nxt = (w_hit && (w_route != '0)) ? SEND : IDLE;
            SEND:    if (w_all_done || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Packet latch, pending vector, SEND timer and routed counter.
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            r_pkt     <= '0;
            r_pending <= '0;
            r_timer   <= '0;
            r_rt_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pkt_in_vld_in) r_pkt <= bus.pkt_in_data_in;
                end
                MATCH: begin
                    r_pending <= w_hit ? w_route : '0;
                    r_timer   <= '0;
                end
                SEND: begin
                    r_pending <= w_timeout ? '0 : w_pending_after;
                    r_timer   <= r_timer + 32'd1;
                    if (w_all_done) r_rt_cnt <= r_rt_cnt + 32'd1;
                end
                default: r_pending <= '0;
            endcase
        end
    end

    assign rt_cnt_out = r_rt_cnt;

`ifdef PKT_ROUTER_MC_DROP_CNT_EN
    logic [31:0] r_drp_cnt;
    logic        w_drop;

    assign w_drop = ((r_state == MATCH) && !(w_hit && (w_route != '0))) ||
                    ((r_state == SEND) && w_timeout);

    // Count no-match, zero-route and timeout drops.
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb)    r_drp_cnt <= '0;
        else if (w_drop) r_drp_cnt <= r_drp_cnt + 32'd1;
    end

    assign drp_cnt_out = r_drp_cnt;
`else
    assign drp_cnt_out = 32'd0;
`endif

endmodule
`default_nettype wire
